// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with register-file write-through for the ID stage.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_inMEMWB,
    input  logic          flush_inMEMWB,
    input  logic          valid_inJAL,
    input  logic [DW-1:0] DataAddr_inJAL,
    input  logic [AW-1:0] rd_Or_rt_inJAL,
    input  logic [DW-1:0] MemData_inMEM,
    input  logic          MemtoReg_inMEM,
    input  logic          RegWrite_inMEM,
    input  logic [AW-1:0] rs_inID,
    input  logic [AW-1:0] rt_inID,
    input  logic [DW-1:0] rfA_inID,
    input  logic [DW-1:0] rfB_inID,
`ifdef MEM_WB_RETIRE_CNT_EN
    input  logic          retire_clr,
    output logic [31:0]   retire_cnt,
`endif
    output logic [DW-1:0] WbData,
    output logic [AW-1:0] WbReg,
    output logic          WbEn,
    output logic [DW-1:0] A_outID,
    output logic [DW-1:0] B_outID,
    output logic          valid_outMEMWB
);

    logic          valid_q, valid_d;
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic [DW-1:0] dataaddr_q, dataaddr_d;
    logic [DW-1:0] memdata_q, memdata_d;
    logic [AW-1:0] rd_q, rd_d;

    // Priority: flush > stall > load.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        dataaddr_d = dataaddr_q;
        memdata_d  = memdata_q;
        rd_d       = rd_q;
        if (flush_inMEMWB) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            dataaddr_d = '0;
            memdata_d  = '0;
            rd_d       = '0;
        end else if (!stall_inMEMWB) begin
            valid_d    = valid_inJAL;
            regwrite_d = RegWrite_inMEM & valid_inJAL;
            memtoreg_d = MemtoReg_inMEM;
            dataaddr_d = DataAddr_inJAL;
            memdata_d  = MemData_inMEM;
            rd_d       = rd_Or_rt_inJAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            dataaddr_q <= '0;
            memdata_q  <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            dataaddr_q <= dataaddr_d;
            memdata_q  <= memdata_d;
            rd_q       <= rd_d;
        end
    end

    always_comb begin
        WbData         = memtoreg_q ? memdata_q : dataaddr_q;
        WbReg          = rd_q;
        // $0 is never written, which also keeps index 0 out of the bypass.
        WbEn           = valid_q & regwrite_q & (rd_q != '0);
        valid_outMEMWB = valid_q;
        A_outID        = (WbEn && (rs_inID == rd_q)) ? WbData : rfA_inID;
        B_outID        = (WbEn && (rt_inID == rd_q)) ? WbData : rfB_inID;
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire_clr) begin
            retire_cnt_q <= '0;
        end else if (valid_q && !stall_inMEMWB) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
MEM/WB pipeline register of the 5-stage, non-forwarding MIPS pipeline. It captures the writeback bundle produced by the JAL select logic (ALU/link result and destination register), the data-memory read word and the writeback control bits. It drives the register-file write port with the final writeback value. It also provides a same-cycle write-through path so ID-stage register reads see the value being retired, with stall/flush support and an optional retired-instruction counter.

Parameters:
DW, 32, datapath width
AW, 5, register index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall_inMEMWB  in  1  hold current contents
flush_inMEMWB  in  1  insert bubble
valid_inJAL  in  1  MEM-stage instruction is real (not bubble)
DataAddr_inJAL  in  DW  ALU result or PC+8 (already JAL-selected)
rd_Or_rt_inJAL  in  AW  destination register (already JAL-selected)
MemData_inMEM  in  DW  data-memory read word
MemtoReg_inMEM  in  1  1 = write memory word, 0 = write DataAddr
RegWrite_inMEM  in  1  instruction writes a register
rs_inID  in  AW  ID read port A index
rt_inID  in  AW  ID read port B index
rfA_inID  in  DW  register-file read data A
rfB_inID  in  DW  register-file read data B
WbData  out  DW  register-file write data
WbReg  out  AW  register-file write index
WbEn  out  1  register-file write enable
A_outID  out  DW  ID operand A after write-through
B_outID  out  DW  ID operand B after write-through
valid_outMEMWB  out  1  WB stage holds a real instruction

Behaviour:
- Reset (async, rst=1): all registered state cleared; valid_outMEMWB=0, WbEn=0, WbData=0, WbReg=0. A_outID/B_outID follow rfA/rfB.
- Registered fields: valid, RegWrite, MemtoReg, DataAddr, MemData, rd. Latency is 1 cycle from MEM inputs to WB outputs.
- Edge update priority: flush > stall > load.
  - flush: valid=0, RegWrite=0; data fields don't-care (cleared to 0).
  - stall (no flush): all fields hold.
  - otherwise: load inputs; stored valid = valid_inJAL; stored RegWrite = RegWrite_inMEM & valid_inJAL.
- Simultaneous flush+stall: flush wins.
- WbData = MemtoReg ? MemData : DataAddr (combinational from registered fields).
- WbReg = registered rd.
- WbEn = valid & RegWrite & (rd != 0). Writes to $0 are always suppressed.
- While stalled, WbEn stays asserted for the held instruction. Rewriting the same value is idempotent and permitted.
- Write-through (replaces half-cycle register-file write):
  - A_outID = (WbEn && rs_inID==WbReg) ? WbData : rfA_inID.
  - B_outID is identical using rt_inID and rfB_inID.
  - Index 0 never bypasses, because WbEn is 0 for rd 0.
- No internal FSM beyond the valid bit. A bubble enters whenever valid_inJAL=0 or flush is asserted.
- Reset mid-stall: reset dominates immediately; outputs return to reset values asynchronously.

Optional Feature:
MEM_WB_RETIRE_CNT_EN
- Defined:
  - Adds output retire_cnt[31:0] and input retire_clr.
  - Counter increments by 1 on each rising edge where valid_outMEMWB=1 and stall_inMEMWB=0, i.e. one count per retired instruction, including non-writing ones.
  - retire_clr synchronously zeroes the counter and has priority over increment.
  - Async reset to 0; wraps from 0xFFFFFFFF to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with loaded contents -> valid_outMEMWB=0, WbEn=0, WbData=0 immediately, without waiting for a clock edge.
- Load ALU op: valid=1, RegWrite=1, MemtoReg=0, DataAddr=0x0000_1234, rd=8 -> next cycle WbEn=1, WbReg=8, WbData=0x1234.
- JAL/load/$0 sequence:
  - Load with MemtoReg=1, MemData=0xDEAD_BEEF, rd=9 -> WbData=0xDEADBEEF.
  - Link result DataAddr=0x0040_0008, rd=31 -> WbReg=31, WbData=0x00400008.
  - rd=0 with RegWrite=1 -> WbEn=0.
- Stall/flush:
  - Hold stall 3 cycles with new inputs applied -> outputs unchanged, WbEn held.
  - Assert flush and stall together -> next cycle valid=0, WbEn=0.
- Write-through: WB retiring rd=5, value 0xA5A5_0001; rs=5, rt=6, rfA=0, rfB=0x77 -> A_outID=0xA5A50001, B_outID=0x77. Repeat with WbEn=0 -> A_outID=0.
- With MEM_WB_RETIRE_CNT_EN: 10 valid instructions with 2 bubbles and 1 stall cycle interleaved -> retire_cnt=10. Then pulse retire_clr -> 0. Preload 0xFFFFFFFF and retire one -> 0.
